// File: rtl/code_length_checker.sv
// +-----------------------------------------------------------------------------+
// | code_length_checker: keypad lock/reprogram entry-length tracker            |
// | Rev 1.0                                                                    |
// +-----------------------------------------------------------------------------+
`default_nettype none

module code_length_checker #(
  parameter int KEY_W        = 4,
  parameter int CNT_W        = 4,
  parameter int MIN_LEN      = 4,
  parameter int MAX_LEN      = 6,
  parameter int PROG_LEN     = 6,
  parameter int PROG_ENTRIES = 3,
  parameter int LOCK_KEY     = 9,
  parameter int PROG_KEY     = 8,
  parameter int CLR_KEY      = 7,
  parameter int TIMEOUT      = 0,
  parameter int TO_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key,
  input  logic             input_wrong,
  output logic             busy,
  output logic             in_prog,
  output logic [2:0]       prog_idx,
  output logic [CNT_W-1:0] digit_count,
  output logic             lock_done,
  output logic             lock_len_ok,
  output logic             prog_done,
  output logic             prog_len_ok,
  output logic             abort
);

  localparam logic [KEY_W-1:0] K_LOCK   = KEY_W'(LOCK_KEY);
  localparam logic [KEY_W-1:0] K_PROG   = KEY_W'(PROG_KEY);
  localparam logic [KEY_W-1:0] K_CLR    = KEY_W'(CLR_KEY);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       LAST_IDX = 3'(PROG_ENTRIES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK = 2'd1, PROG = 2'd2} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n, count_inc;
  logic             sat, sat_n, bad, bad_n, prog_bad;
  logic [2:0]       idx, idx_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic             lock_done_n, lock_ok_n, prog_done_n, prog_ok_n, abort_n;
  logic             is_lock, is_prog, is_clr, timed_out;

  assign is_lock   = key_valid && (key == K_LOCK);
  assign is_prog   = key_valid && (key == K_PROG);
  assign is_clr    = key_valid && (key == K_CLR);
  assign timed_out = (TIMEOUT != 0) && (to_cnt == TO_LAST) && !key_valid;
  assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;
  assign prog_bad  = bad || sat || (int'(count) != PROG_LEN);

  always_comb begin
    state_n     = state;
    count_n     = count;
    sat_n       = sat;
    bad_n       = bad;
    idx_n       = idx;
    to_cnt_n    = to_cnt;
    lock_done_n = 1'b0;
    lock_ok_n   = 1'b0;
    prog_done_n = 1'b0;
    prog_ok_n   = 1'b0;
    abort_n     = 1'b0;
    if (state == IDLE) begin
      to_cnt_n = '0;
      if (!input_wrong) begin
        if (is_lock) begin
          state_n = LOCK;
          count_n = '0;
          sat_n   = 1'b0;
        end else if (is_prog) begin
          state_n = PROG;
          count_n = '0;
          sat_n   = 1'b0;
          bad_n   = 1'b0;
          idx_n   = '0;
        end
      end
    end else begin
      to_cnt_n = key_valid ? '0 : to_cnt + 1'b1;
      if (input_wrong || is_clr || timed_out) begin
        state_n  = IDLE;
        count_n  = '0;
        sat_n    = 1'b0;
        bad_n    = 1'b0;
        idx_n    = '0;
        to_cnt_n = '0;
        abort_n  = 1'b1;
      end else if (state == LOCK) begin
        if (is_lock) begin
          state_n     = IDLE;
          count_n     = '0;
          sat_n       = 1'b0;
          to_cnt_n    = '0;
          lock_done_n = 1'b1;
          lock_ok_n   = !sat && (int'(count) >= MIN_LEN) && (int'(count) <= MAX_LEN);
        end else if (key_valid && !is_prog) begin
          count_n = count_inc;
          sat_n   = sat || (count_inc == CNT_MAX);
        end
      end else begin
        // A PROG_KEY closes the current entry; bad is sticky across entries
        if (is_prog) begin
          count_n = '0;
          sat_n   = 1'b0;
          bad_n   = prog_bad;
          if (idx == LAST_IDX) begin
            state_n     = IDLE;
            idx_n       = '0;
            bad_n       = 1'b0;
            to_cnt_n    = '0;
            prog_done_n = 1'b1;
            prog_ok_n   = !prog_bad;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else if (key_valid && !is_lock) begin
          count_n = count_inc;
          sat_n   = sat || (count_inc == CNT_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      sat         <= 1'b0;
      bad         <= 1'b0;
      idx         <= '0;
      to_cnt      <= '0;
      lock_done   <= 1'b0;
      lock_len_ok <= 1'b0;
      prog_done   <= 1'b0;
      prog_len_ok <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      sat         <= sat_n;
      bad         <= bad_n;
      idx         <= idx_n;
      to_cnt      <= to_cnt_n;
      lock_done   <= lock_done_n;
      lock_len_ok <= lock_ok_n;
      prog_done   <= prog_done_n;
      prog_len_ok <= prog_ok_n;
      abort       <= abort_n;
    end
  end

  assign busy        = (state != IDLE);
  assign in_prog     = (state == PROG);
  assign prog_idx    = idx;
  assign digit_count = count;

endmodule

`default_nettype wire
